// File: rtl/multi_orchestrator_pkg.sv
// Shared constants and the per-priority rotate/mirror rule for the object orchestrator.
package orchestrator_pkg;

  localparam logic [3:0] TENSION_B = 4'd4;
  localparam logic [3:0] TENSION_L = 4'd6;
  localparam logic [3:0] TENSION_R = 4'd10;
  localparam logic [3:0] TENSION_T = 4'd14;

  localparam int              LFSR_W    = 10;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'b10_0100_0000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h3FF;

  // Returns {rot, mir}; the four rules rotate which edge combination wins.
  function automatic logic [1:0] rot_mir(input logic [1:0] prio,
                                         input logic l, input logic r,
                                         input logic t, input logic b);
    logic rot;
    logic mir;
    rot = 1'b0;
    mir = 1'b0;
    case (prio)
      2'd0: begin
        rot = (l | r) & ~(t | b);
        mir = (t | (l & ~r)) & ~b;
      end
      2'd1: begin
        rot = l | r;
        mir = (l | (t & ~b)) & ~r;
      end
      2'd2: begin
        rot = (l | r) & ~(t | b);
        mir = t | (l & ~b);
      end
      default: begin
        rot = l | r;
        mir = l | (t & ~r);
      end
    endcase
    return {rot, mir};
  endfunction

endpackage

// File: rtl/multi_orchestrator_impact_arbiter.sv
// Round-robin impact grant with per-object retrigger holdoff counters.
module impact_arbiter #(
  parameter int N_OBJ   = 2,
  parameter int HOLDOFF = 15,
  parameter int IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_OBJ-1:0] armed,
  input  logic             tick,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt [N_OBJ];
  logic [N_OBJ-1:0] cand;
  logic [N_OBJ-1:0] gnt_vec;

  function automatic int wrap_idx(input int base, input int k);
    return (base + k >= N_OBJ) ? base + k - N_OBJ : base + k;
  endfunction

  // Scan from the farthest slot back so the one closest to rr_ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    cand      = '0;
    for (int i = 0; i < N_OBJ; i++) cand[i] = armed[i] && (cnt[i] == '0);
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (cand[wrap_idx(int'(rr_ptr), k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(wrap_idx(int'(rr_ptr), k));
      end
    end
    gnt_vec[gnt_idx] = gnt_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < N_OBJ; i++) cnt[i] <= '0;
    end else begin
      if (gnt_valid) rr_ptr <= (gnt_idx == IDX_W'(N_OBJ - 1)) ? '0 : gnt_idx + 1'b1;
      for (int i = 0; i < N_OBJ; i++) begin
        if (armed[i] && (gnt_vec[i] || cnt[i] != '0)) cnt[i] <= CNT_W'(HOLDOFF);
        else if (tick && cnt[i] != '0)                 cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_orchestrator.sv
// Frame scheduler for N bouncing objects: edge-hit latching, vblank strobes,
// kinematics/transform sequencing and round-robin impact sound arbitration.
module multi_orchestrator
  import orchestrator_pkg::*;
#(
  parameter int N_OBJ     = 2,
  parameter int COORD_W   = 10,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int KIN_OFS   = 5,
  parameter int XFORM_OFS = 10,
  parameter int IMPACT_W  = 3,
  parameter int HOLDOFF   = 15,
  parameter int SDIV_W    = 10,
  localparam int IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COORD_W-1:0]        vga_x,
  input  logic [COORD_W-1:0]        vga_y,
  input  logic [N_OBJ-1:0]          obj_hit,
  input  logic [N_OBJ*IMPACT_W-1:0] obj_impact,
  input  logic [N_OBJ-1:0]          obj_enable,
  input  logic                      pause_kinematics,
  input  logic                      mute_sound,
  output logic [N_OBJ-1:0]          update_collision,
  output logic [N_OBJ-1:0]          rotate_collision,
  output logic [N_OBJ-1:0]          mirror_collision,
  output logic                      update_kinematics,
  output logic                      update_transform,
  output logic                      update_resonator,
  output logic [N_OBJ-1:0]          handle_impact,
  output logic [IMPACT_W-1:0]       trigger_resonator,
  output logic [IDX_W-1:0]          trigger_obj,
  output logic [3:0]                tension,
  output logic [N_OBJ-1:0]          round_dir,
  output logic [1:0]                color_entropy
);

  logic [N_OBJ-1:0]  flag_l, flag_r, flag_t, flag_b;
  logic [N_OBJ-1:0]  any_flag, armed, col_nxt, rot_nxt, mir_nxt;
  logic [1:0]        rm [N_OBJ];
  logic [LFSR_W-1:0] lfsr;
  logic [1:0]        prio;
  logic [SDIV_W-1:0] sdiv;
  logic              quiet, tick, gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IMPACT_W-1:0] gnt_impact;
  logic [3:0]        gnt_tension;
  logic              at_frame, at_kin, at_xform, in_rows;
  logic              edge_r, edge_l, edge_b, edge_t;

  assign any_flag = flag_l | flag_r | flag_t | flag_b;
  assign quiet    = ~|(any_flag & obj_enable);
  assign tick     = quiet && (sdiv == '0);

  assign at_frame = (vga_y == COORD_W'(V_ACTIVE)) && (vga_x == '0);
  assign at_kin   = (vga_y == COORD_W'(V_ACTIVE + KIN_OFS)) && (vga_x == '0);
  assign at_xform = (vga_y == COORD_W'(V_ACTIVE + XFORM_OFS)) && (vga_x == '0);
  assign in_rows  = vga_y < COORD_W'(V_ACTIVE);
  assign edge_r   = in_rows && (vga_x == COORD_W'(H_ACTIVE - 1));
  assign edge_l   = in_rows && (vga_x == '0);
  assign edge_b   = (vga_y == COORD_W'(V_ACTIVE - 1)) && (vga_x < COORD_W'(H_ACTIVE));
  assign edge_t   = (vga_y == '0) && (vga_x < COORD_W'(H_ACTIVE));

  always_comb begin
    armed   = '0;
    col_nxt = '0;
    rot_nxt = '0;
    mir_nxt = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      armed[i]   = obj_enable[i] && any_flag[i] &&
                   (obj_impact[i*IMPACT_W +: IMPACT_W] != '0);
      rm[i]      = rot_mir(prio + 2'(i), flag_l[i], flag_r[i], flag_t[i], flag_b[i]);
      col_nxt[i] = obj_enable[i] & any_flag[i];
      rot_nxt[i] = obj_enable[i] & rm[i][1];
      mir_nxt[i] = obj_enable[i] & rm[i][0];
    end
  end

  impact_arbiter #(
    .N_OBJ  (N_OBJ),
    .HOLDOFF(HOLDOFF),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .armed    (armed),
    .tick     (tick),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // A granted object is armed, so at least one of its flags is set.
  assign gnt_impact  = obj_impact[gnt_idx*IMPACT_W +: IMPACT_W];
  assign gnt_tension = flag_b[gnt_idx] ? TENSION_B :
                       flag_l[gnt_idx] ? TENSION_L :
                       flag_r[gnt_idx] ? TENSION_R : TENSION_T;

  always_ff @(posedge clk) begin
    if (rst) begin
      update_collision  <= '0;
      rotate_collision  <= '0;
      mirror_collision  <= '0;
      update_kinematics <= 1'b0;
      update_transform  <= 1'b0;
      update_resonator  <= 1'b0;
      handle_impact     <= '0;
      trigger_resonator <= '0;
      trigger_obj       <= '0;
      tension           <= '0;
      flag_l            <= '0;
      flag_r            <= '0;
      flag_t            <= '0;
      flag_b            <= '0;
      lfsr              <= LFSR_SEED;
      prio              <= 2'd0;
      sdiv              <= '0;
    end else begin
      update_collision  <= '0;
      rotate_collision  <= '0;
      mirror_collision  <= '0;
      update_kinematics <= 1'b0;
      update_transform  <= 1'b0;
      update_resonator  <= tick;
      handle_impact     <= '0;
      trigger_resonator <= '0;
      if (quiet) sdiv <= sdiv + 1'b1;
      if (gnt_valid) begin
        handle_impact     <= N_OBJ'(1) << gnt_idx;
        trigger_resonator <= mute_sound ? '0 : gnt_impact;
        trigger_obj       <= gnt_idx;
        tension           <= gnt_tension;
      end
      // Corner pixels fall into the L/R branches before B/T are considered.
      if (at_frame) begin
        lfsr             <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        prio             <= prio + 2'd1;
        update_collision <= col_nxt;
        rotate_collision <= rot_nxt;
        mirror_collision <= mir_nxt;
      end else if (at_kin) begin
        update_kinematics <= ~pause_kinematics;
      end else if (at_xform) begin
        update_transform <= 1'b1;
        flag_l           <= '0;
        flag_r           <= '0;
        flag_t           <= '0;
        flag_b           <= '0;
      end else if (edge_r) begin
        flag_r <= flag_r | (obj_hit & obj_enable);
      end else if (edge_l) begin
        flag_l <= flag_l | (obj_hit & obj_enable);
      end else if (edge_b) begin
        flag_b <= flag_b | (obj_hit & obj_enable);
      end else if (edge_t) begin
        flag_t <= flag_t | (obj_hit & obj_enable);
      end
    end
  end

  assign round_dir     = lfsr[N_OBJ-1:0];
  assign color_entropy = lfsr[LFSR_W-1 -: 2];

endmodule

// File: doc/multi_orchestrator.md
Name: multi_orchestrator

Overview:
- Frame-level scheduler for N independent bouncing objects sharing one VGA raster and one resonator voice.
- Latches per-object screen-edge hits during the active frame and issues per-object collision, rotate and mirror strobes in vertical blank.
- Sequences the kinematics and transform updates, and arbitrates impact sounds round-robin with a per-object retrigger holdoff.
- Sits between the raster generator, the per-object capsule renderers and the single resonator.

Parameters:
N_OBJ, 2, number of objects (1..8)
COORD_W, 10, width of vga_x/vga_y
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
KIN_OFS, 5, lines after V_ACTIVE for the kinematics strobe
XFORM_OFS, 10, lines after V_ACTIVE for the transform strobe (> KIN_OFS)
IMPACT_W, 3, impact magnitude width
HOLDOFF, 15, retrigger holdoff in sample ticks
SDIV_W, 10, sample divider width (tick every 2^SDIV_W quiet cycles)
(localparam IDX_W = max(1, clog2(N_OBJ)))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
vga_x  in  COORD_W  raster column
vga_y  in  COORD_W  raster line
obj_hit  in  N_OBJ  per-object pixel-inside-capsule flag
obj_impact  in  N_OBJ*IMPACT_W  per-object impact magnitude; slice i = bits [i*IMPACT_W +: IMPACT_W]
obj_enable  in  N_OBJ  disabled objects latch no hits and get no strobes
pause_kinematics  in  1  suppresses update_kinematics
mute_sound  in  1  forces trigger_resonator to 0
update_collision  out  N_OBJ  per-object pulse
rotate_collision  out  N_OBJ  per-object pulse
mirror_collision  out  N_OBJ  per-object pulse
update_kinematics  out  1  pulse
update_transform  out  1  pulse
update_resonator  out  1  sample-tick pulse
handle_impact  out  N_OBJ  one-hot pulse to the granted object
trigger_resonator  out  IMPACT_W  granted magnitude, 1-cycle pulse
trigger_obj  out  IDX_W  index of the last granted object (held)
tension  out  4  resonator tension (held)
round_dir  out  N_OBJ  bit i = lfsr[i]
color_entropy  out  2  lfsr[9:8]

Behaviour:
- All outputs are registered. Every pulse output defaults to 0 each cycle.
- Reset: pulse outputs 0; tension 0; trigger_obj 0; lfsr 10'h3FF; prio 0; rr_ptr 0; sample counter 0; all holdoff counters 0; all edge flags L/R/T/B cleared.
- Raster decode, as a priority chain evaluated in this order, per enabled object i:
  - (V_ACTIVE,0) frame event.
  - (V_ACTIVE+KIN_OFS,0): update_kinematics <= !pause_kinematics.
  - (V_ACTIVE+XFORM_OFS,0): update_transform <= 1; clear all flags.
  - y<V_ACTIVE && x==H_ACTIVE-1: R_i |= hit_i.
  - y<V_ACTIVE && x==0: L_i |= hit_i.
  - y==V_ACTIVE-1 && x<H_ACTIVE: B_i |= hit_i.
  - y==0 && x<H_ACTIVE: T_i |= hit_i.
  - Corner pixels therefore set only L or R.
- Frame event:
  - lfsr <= {lfsr[8:0], ^(lfsr & 10'b1001000000)}; prio <= prio+1 (2-bit wrap).
  - Per object, update_collision[i] <= L|R|T|B.
  - Per object, p_i = (prio+i) mod 4 selects the rotate/mirror rule:
    - p0: rot=(L|R)&!(T|B); mir=(T|(L&!R))&!B
    - p1: rot=L|R; mir=(L|(T&!B))&!R
    - p2: rot=(L|R)&!(T|B); mir=T|(L&!B)
    - p3: rot=L|R; mir=L|(T&!R)
- Impact arbitration, evaluated every cycle independently of the raster decode:
  - armed_i = enable_i & (L|R|T|B)_i & impact_i!=0.
  - cand_i = armed_i & cnt_i==0.
  - Grant at most one candidate per cycle, round-robin starting at rr_ptr. On a grant g:
    - rr_ptr <= g+1 mod N_OBJ.
    - handle_impact[g] <= 1.
    - trigger_resonator <= mute ? 0 : impact_g.
    - trigger_obj <= g.
    - tension <= first set flag of g in the order B=4, L=6, R=10, T=14.
  - cnt_i <= HOLDOFF when armed_i and (granted_i or cnt_i!=0). An ungranted candidate keeps cnt 0 and retries the next cycle.
- Sample divider:
  - Counts only while no enabled object has any flag set; it holds otherwise.
  - While counting, a counter value of 0 gives update_resonator <= 1, and every cnt_i that is nonzero and not being reloaded decrements by 1.
- Strobes on disabled objects are 0. Deasserting enable_i while it is armed stops any further grants to object i.

Decomposition:
- Package orchestrator_pkg: tension constants (4/6/10/14), LFSR width/taps/seed, and a function rot_mir(prio, L,R,T,B) returning {rot, mir}.
- Sub-module impact_arbiter (N_OBJ): round-robin grant plus per-object holdoff counters.
- Raster decode, edge flags, LFSR and sample divider stay in the top level.

Test Plan:
- N_OBJ=2; obj 0 hit at (639,100), prio=0 -> at (480,0): update_collision=01, rotate=01, mirror=00; next frame the flags are cleared after y=490.
- Obj 0 hits top only with prio=2 -> mirror[0]=1, rotate[0]=0; obj 1 hits top in the same frame (p=3) -> mirror[1]=1, rotate[1]=0.
- Both objects armed, impact 5 and 3, cnt=0, rr_ptr=0 -> cycle t: handle=01, trigger=5; t+1: handle=10, trigger=3, trigger_obj=1; no further triggers until cnt returns to 0.
- mute_sound=1 with obj 0 bottom impact 7 -> handle_impact[0]=1, trigger_resonator=0, tension=4.
- No flags set for 2^SDIV_W cycles -> exactly one update_resonator pulse; cnt goes 15->14.
- pause_kinematics=1 -> no update_kinematics pulse at (485,0); rst mid-frame -> lfsr=3FF, flags cleared, no pulses on the next cycle.
